// File: rtl/pbus_arbiter.sv
// PBus master arbiter: grants one of NM masters per transaction and sequences
// the dead cycle, the ready wait and the timeout abort on the shared bus.
module pbus_arbiter #(
  parameter int NM      = 2,
  parameter int GW      = 1,
  parameter int TIMEOUT = 255,
  parameter int PRIO0   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*NM-1:0]      m_req,
  input  logic [15*NM-1:0]     m_addr,
  input  logic [16*NM-1:0]     m_wdata,
  input  logic [2*NM-1:0]      m_be,
  input  logic [NM-1:0]        m_aspace,
  output logic [NM-1:0]        m_gnt,
  output logic [NM-1:0]        m_done,
  output logic [NM-1:0]        m_err,
  output logic [15:0]          m_rdata,
  output logic [1:0]           pbus_req,
  output logic [14:0]          pbus_addr,
  output logic [15:0]          pbus_wdata,
  output logic [1:0]           pbus_be,
  output logic                 pbus_aspace,
  input  logic [15:0]          pbus_rdata,
  input  logic                 pbus_rdy,
  output logic                 pbus_going,
  output logic [GW-1:0]        grantee
);

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_WAIT, S_ERR} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grantee_q, grantee_d;
  logic [GW-1:0]   rr_last_q, rr_last_d;
  logic [7:0]      timer_q, timer_d;
  logic [1:0]      req_q, req_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [NM-1:0]   done_q, done_d;

  logic [1:0]      req_a    [NM];
  logic [14:0]     addr_a   [NM];
  logic [15:0]     wdata_a  [NM];
  logic [1:0]      be_a     [NM];
  logic [NM-1:0]   req_vld;

  for (genvar i = 0; i < NM; i++) begin : g_unpack
    assign req_a[i]   = m_req[2*i +: 2];
    assign addr_a[i]  = m_addr[15*i +: 15];
    assign wdata_a[i] = m_wdata[16*i +: 16];
    assign be_a[i]    = m_be[2*i +: 2];
    assign req_vld[i] = m_req[2*i];
  end

  // Winner selection: optional absolute priority for master 0, else
  // round-robin starting just after the last granted master.
  logic          win_vld;
  logic [GW-1:0] win_idx;
  logic [GW-1:0] cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = rr_last_q;
    if ((PRIO0 != 0) && req_vld[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int k = 0; k < NM; k++) begin
        cand = (cand == GW'(NM - 1)) ? '0 : cand + GW'(1);
        if (!win_vld && req_vld[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grantee_d = grantee_q;
    rr_last_d = rr_last_q;
    timer_d   = timer_q;
    req_d     = req_q;
    rdata_d   = rdata_q;
    done_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          grantee_d = win_idx;
          rr_last_d = win_idx;
          req_d     = req_a[win_idx];
          state_d   = S_DEAD;
        end
      end
      S_DEAD: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pbus_rdy) begin
          state_d           = S_IDLE;
          done_d[grantee_q] = 1'b1;
          if (req_q[1]) rdata_d = pbus_rdata;
        end else begin
          // saturating so a disabled timeout can wait forever without wrapping
          if (timer_q != 8'hFF) timer_d = timer_q + 8'd1;
          if ((TIMEOUT != 0) && (timer_q == 8'(TIMEOUT - 1))) state_d = S_ERR;
        end
      end
      S_ERR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grantee_q <= '0;
      rr_last_q <= GW'(NM - 1);
      timer_q   <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      grantee_q <= grantee_d;
      rr_last_q <= rr_last_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      done_q    <= done_d;
    end
  end

  assign pbus_going  = (state_q == S_DEAD) || (state_q == S_WAIT);
  assign pbus_req    = pbus_going ? req_q : 2'b00;
  assign pbus_addr   = addr_a[grantee_q];
  assign pbus_wdata  = wdata_a[grantee_q];
  assign pbus_be     = be_a[grantee_q];
  assign pbus_aspace = m_aspace[grantee_q];
  assign m_done      = done_q;
  assign m_rdata     = rdata_q;
  assign grantee     = grantee_q;

  always_comb begin
    m_gnt            = '0;
    m_err            = '0;
    m_gnt[grantee_q] = pbus_going;
    m_err[grantee_q] = (state_q == S_ERR);
  end

endmodule

// File: doc/pbus_arbiter.md
Name: pbus_arbiter

Overview:
- Parameterised PBus master arbiter and transaction sequencer. It replaces the fixed two-master IDLE/DEAD/WAIT grant logic in the FPGA top level.
- It accepts up to four masters: COP, CPU and future DMA/debug engines. It grants one master per transaction and muxes that master's address, data, byte-enable and address-space onto the shared PBus.
- It sequences the dead cycle and the ready wait, and aborts transactions whose target never asserts ready.
- It returns captured read data plus a done or error pulse to the granted master.

Parameters:
NM, 2, number of masters (2..4).
GW, 1, grantee index width (1 for NM=2, 2 for NM=3..4).
TIMEOUT, 255, maximum WAIT cycles before abort; 0 disables the timeout.
PRIO0, 1, 1 = master 0 (COP) has absolute priority; 0 = pure round-robin.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m_req  in  2*NM  per master {rd,valid}, slice i = bits [2i+1:2i]
m_addr  in  15*NM  per master word address [15:1]
m_wdata  in  16*NM  per master write data
m_be  in  2*NM  per master byte enables
m_aspace  in  NM  per master address space select
m_gnt  out  NM  one-hot, high while the master owns the bus (DEAD and WAIT)
m_done  out  NM  one-cycle completion pulse
m_err  out  NM  one-cycle timeout-abort pulse
m_rdata  out  16  read data captured at completion
pbus_req  out  2  bus request {rd,valid}
pbus_addr  out  15  bus address [15:1]
pbus_wdata  out  16  bus write data
pbus_be  out  2  bus byte enables
pbus_aspace  out  1  bus address space
pbus_rdata  in  16  selected target read data
pbus_rdy  in  1  AND of all target ready signals
pbus_going  out  1  bus owned (DEAD or WAIT)
grantee  out  GW  index of the current/last granted master

Behaviour:
- Reset:
  - Applies on the next clk edge while reset=1, including mid-transaction.
  - State=IDLE, grantee=0, rr_last=NM-1, timer=0, req_q=0, m_rdata=0.
  - All m_gnt, m_done and m_err are 0; pbus_going=0; pbus_req=0.
  - No done/err pulse is generated for an aborted transaction.
- States: IDLE, DEAD, WAIT, ERR.
- IDLE:
  - If any m_req[2i]=1, select a winner and capture grantee and req_q (that master's {rd,valid}).
  - Set rr_last=winner and go to DEAD.
  - Selection: if PRIO0=1 and master 0 is requesting, master 0 wins. Otherwise, search from rr_last+1 upward, wrapping at NM-1 to 0; the first requester wins.
  - With no request, stay in IDLE.
- DEAD: one cycle; timer=0; go to WAIT.
- WAIT:
  - If pbus_rdy=1: go to IDLE; pulse m_done[grantee] in the following cycle. If req_q[1]=1, also latch m_rdata<=pbus_rdata.
  - Otherwise timer increments. If TIMEOUT!=0 and timer==TIMEOUT-1, go to ERR.
  - pbus_rdy=1 in the same cycle as expiry: rdy wins (normal completion).
- ERR: one cycle; pbus_req=0; m_err[grantee]=1; next state IDLE.
- Combinational bus outputs:
  - pbus_going=1 in DEAD/WAIT.
  - pbus_req = pbus_going ? req_q : 2'b00.
  - pbus_addr/wdata/be/aspace are always muxed from the master selected by grantee.
- m_gnt[grantee]=pbus_going; all other m_gnt bits are 0.
- Master rules:
  - A master holds addr, wdata, be and aspace stable from request until its m_done or m_err.
  - A master dropping m_req mid-transaction has no effect on the transaction, because req_q is latched.
- Back-to-back:
  - A request sampled in the cycle m_done pulses (state IDLE) is granted that same edge.
  - Minimum transaction is 3 cycles (IDLE->DEAD->WAIT with immediate rdy).
- Timer width is 8 bits; no wrap occurs because ERR triggers first. With TIMEOUT=0 the timer saturates at 255 and WAIT can last indefinitely.

Test Plan:
1. Reset, then master 1 issues a write (m_req1=2'b01, addr=15'h0801, wdata=16'hBEEF), pbus_rdy=1 -> gnt1 high for 2 cycles, pbus_addr=0801, pbus_req=01, done1 pulses on cycle 3, m_err=0.
2. NM=2, PRIO0=1, both masters request reads continuously -> master 0 granted every transaction, master 1 never granted.
3. NM=4, PRIO0=0, masters 0-3 request continuously -> grant order 0,1,2,3,0; each transaction is 3 cycles when rdy is held 1.
4. Master 0 read, pbus_rdy held low 5 cycles then high with pbus_rdata=16'h1234 -> WAIT lasts 6 cycles, done0 pulses, m_rdata=1234.
5. TIMEOUT=4, rdy never asserted -> ERR entered after 4 WAIT cycles, err pulse for the granted master, pbus_req=0 during ERR, back to IDLE.
6. reset asserted in WAIT -> next cycle IDLE, pbus_going=0, no done/err pulse; a pending request is re-granted from master 0.
